// File: rtl/post_spi_host.sv
// rtl/post_spi_host.sv - SPI mode-0 master running 24-bit cmd/addr/data frames to a Post machine programming port
module post_spi_host #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] addr,
  input  logic [3:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [3:0] rdata,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  state_t          state, state_next;
  logic [PW-1:0]   phase;
  logic            hi;
  logic [4:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [23:0]     frame;
  logic [3:0]      rx;
  logic [1:0]      op_q;
  logic            done_q;
  logic [3:0]      rdata_q;
  logic [7:0]      data_byte;
  logic            phase_end;

  assign phase_end = (phase == PH_LAST);

  always_comb begin
    data_byte = 8'h00;
    case (op)
      2'd0:    data_byte = {4'h0, wdata};
      2'd2:    data_byte = {7'h00, wdata[0]};
      default: data_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (hi && phase_end && bit_cnt == 5'd23) state_next = HOLD;
      HOLD:    if (phase_end) state_next = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      hi      <= 1'b0;
      bit_cnt <= 5'd0;
      gap_cnt <= '0;
      frame   <= 24'h0;
      rx      <= 4'h0;
      op_q    <= 2'd0;
      done_q  <= 1'b0;
      rdata_q <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frame   <= {6'b100000, op, addr, data_byte};
            op_q    <= op;
            phase   <= '0;
            hi      <= 1'b0;
            bit_cnt <= 5'd0;
            gap_cnt <= '0;
          end
        end
        SHIFT: begin
          // MISO is captured in the first cycle of each high phase
          if (hi && phase == '0) rx <= {rx[2:0], miso};
          if (phase_end) begin
            phase <= '0;
            hi    <= ~hi;
            if (hi && bit_cnt != 5'd23) begin
              frame   <= {frame[22:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        HOLD: begin
          phase   <= phase_end ? '0 : phase + PW'(1);
          gap_cnt <= '0;
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GAP_LAST) begin
            done_q <= 1'b1;
            if (op_q[0]) rdata_q <= op_q[1] ? {3'b000, rx[0]} : rx;
          end
        end
        default: ;
      endcase
    end
  end

  assign cs    = !(state == SHIFT || state == HOLD);
  assign sck   = (state == SHIFT) && hi;
  assign mosi  = (state == SHIFT) && frame[23];
  assign busy  = (state != IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_post_spi_host.sv
// tb/tb_post_spi_host.sv - bench for post_spi_host: timeline model, SPI slave model, directed frames
module tb_post_spi_host;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic [1:0] op_v    [2];
  logic [7:0] addr_v  [2];
  logic [3:0] wdata_v [2];
  logic       miso_v  [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [3:0] rdata_v [2];
  logic       cs_v    [2];
  logic       sck_v   [2];
  logic       mosi_v  [2];

  post_spi_host #(.CLK_DIV(4), .CS_GAP(2)) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]),
    .cs(cs_v[0]), .sck(sck_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
  );

  post_spi_host #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]),
    .cs(cs_v[1]), .sck(sck_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
  );

  int nvec = 0;
  int nfail = 0;

  // model: each DUT is a timeline indexed by cycles since its accepted START
  bit          act_m [2];
  int          t_m   [2];
  logic [23:0] frm_m [2];
  logic [1:0]  op_m  [2];
  logic [3:0]  rd_m  [2] = '{4'h0, 4'h0};
  logic [7:0]  resp  [2] = '{8'h00, 8'h00};

  // slave-side observation
  bit          psck [2];
  bit          pcs  [2] = '{1'b1, 1'b1};
  int          rises [2];
  logic [23:0] srx [2];
  int          frame_rises [2];
  logic [23:0] frame_rx [2];
  int          hirun [2];
  int          last_hirun [2];
  int          done_cnt [2];

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [7:0] dbyte(input logic [1:0] o, input logic [3:0] w);
    case (o)
      2'd0:    return {4'h0, w};
      2'd2:    return {7'h00, w[0]};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        act_m[d] = 1'b0;
        t_m[d]   = 0;
        rd_m[d]  = 4'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int dt;
        dt = 49 * div_of(d) + gap_of(d) + 1;
        if (start_v[d] && (!act_m[d] || t_m[d] >= dt)) begin
          act_m[d] = 1'b1;
          t_m[d]   = 1;
          op_m[d]  = op_v[d];
          frm_m[d] = {6'b100000, op_v[d], addr_v[d], dbyte(op_v[d], wdata_v[d])};
        end else if (act_m[d]) begin
          t_m[d] = t_m[d] + 1;
          if (t_m[d] == dt && op_m[d][0])
            rd_m[d] = op_m[d][1] ? {3'b000, resp[d][0]} : resp[d][3:0];
        end
      end
    end
  end

  function automatic logic [8:0] expect_out(input int d);
    int dv, gv, t, bi;
    logic c, s, m, b, dn;
    dv = div_of(d); gv = gap_of(d); t = t_m[d];
    c = 1'b1; s = 1'b0; m = 1'b0; b = 1'b0; dn = 1'b0;
    if (act_m[d]) begin
      if (t >= 1 && t <= 49 * dv) c = 1'b0;
      if (t >= 1 && t <= 48 * dv) begin
        s  = ((t - 1) % (2 * dv)) >= dv;
        bi = 23 - (t - 1) / (2 * dv);
        m  = frm_m[d][bi];
      end
      if (t >= 1 && t <= 49 * dv + gv) b = 1'b1;
      if (t == 49 * dv + gv + 1) dn = 1'b1;
    end
    return {c, s, m, b, dn, rd_m[d]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // one cycle: SPI slave behaviour, then the per-cycle model comparison
  task automatic tick();
    logic [8:0] got;
    int bi;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!cs_v[d] && pcs[d]) srx[d] = 24'h0;
      if (cs_v[d] && !pcs[d]) begin
        frame_rises[d] = rises[d];
        frame_rx[d]    = srx[d];
      end
      if (cs_v[d]) begin
        rises[d]  = 0;
        miso_v[d] = 1'b0;
        hirun[d]++;
      end else begin
        if (hirun[d] > 0) begin
          last_hirun[d] = hirun[d];
          hirun[d] = 0;
        end
        if (sck_v[d] && !psck[d]) begin
          rises[d]++;
          srx[d] = {srx[d][22:0], mosi_v[d]};
        end
        if (!sck_v[d]) begin
          bi = 23 - rises[d];
          miso_v[d] = (rises[d] >= 16 && rises[d] < 24) ? resp[d][bi] : 1'b0;
        end
      end
      if (done_v[d]) done_cnt[d]++;
      psck[d] = sck_v[d];
      pcs[d]  = cs_v[d];
      got = {cs_v[d], sck_v[d], mosi_v[d], busy_v[d], done_v[d], rdata_v[d]};
      chk($sformatf("dut%0d_cycle_cs_sck_mosi_busy_done_rdata", d), 32'(got), 32'(expect_out(d)));
    end
  endtask

  task automatic run_frame(input int d, input logic [1:0] o, input logic [7:0] a,
                           input logic [3:0] w, input logic [7:0] r,
                           input int g1, input int g2, output int done_at);
    int n;
    resp[d] = r; op_v[d] = o; addr_v[d] = a; wdata_v[d] = w; start_v[d] = 1'b1;
    done_at = -1;
    n = 0;
    while (done_at < 0 && n < 500) begin
      tick();
      n++;
      start_v[d] = (n == g1 || n == g2);
      op_v[d] = ~o; addr_v[d] = ~a; wdata_v[d] = ~w;
      if (done_v[d]) done_at = n;
    end
    start_v[d] = 1'b0;
    chk($sformatf("dut%0d_frame_done_seen", d), 32'(done_at >= 0), 32'd1);
  endtask

  initial begin
    int da, dc;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; op_v[d] = 2'd0; addr_v[d] = 8'h00;
      wdata_v[d] = 4'h0; miso_v[d] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("reset_cs", 32'(cs_v[0]), 32'd1);
    chk("reset_busy", 32'(busy_v[0]), 32'd0);
    chk("reset_rdata", 32'(rdata_v[0]), 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    run_frame(0, 2'd0, 8'h3C, 4'hA, 8'h00, -1, -1, da);
    chk("wr_code_done_cycle", 32'(da), 32'd199);
    chk("wr_code_mosi_stream", 32'(frame_rx[0]), 32'h803C0A);
    chk("wr_code_sck_rises", 32'(frame_rises[0]), 32'd24);
    chk("wr_code_rdata_kept", 32'(rdata_v[0]), 32'd0);
    tick();

    run_frame(0, 2'd1, 8'h05, 4'h0, 8'h07, -1, -1, da);
    chk("rd_code_rdata", 32'(rdata_v[0]), 32'h7);
    chk("rd_code_mosi_stream", 32'(frame_rx[0]), 32'h810500);
    repeat (2) tick();

    run_frame(0, 2'd3, 8'h22, 4'h0, 8'h01, -1, -1, da);
    chk("rd_data_rdata", 32'(rdata_v[0]), 32'h1);
    run_frame(0, 2'd2, 8'h44, 4'hF, 8'hFF, -1, -1, da);
    chk("wr_data_rdata_kept", 32'(rdata_v[0]), 32'h1);
    chk("wr_data_mosi_stream", 32'(frame_rx[0]), 32'h824401);
    tick();

    dc = done_cnt[0];
    run_frame(0, 2'd0, 8'h12, 4'h5, 8'h00, 50, 120, da);
    chk("ignored_start_done_cycle", 32'(da), 32'd199);
    repeat (5) tick();
    chk("ignored_start_one_done", 32'(done_cnt[0] - dc), 32'd1);

    resp[0] = 8'h00; op_v[0] = 2'd0; addr_v[0] = 8'hA5; wdata_v[0] = 4'h3; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (85) tick();
    chk("abort_pre_sck_high", 32'(sck_v[0]), 32'd1);
    dc = done_cnt[0];
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_async", 32'(cs_v[0]), 32'd1);
    chk("abort_sck_async", 32'(sck_v[0]), 32'd0);
    chk("abort_busy_async", 32'(busy_v[0]), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (260) tick();
    chk("abort_no_done", 32'(done_cnt[0] - dc), 32'd0);
    chk("abort_short_frame_rises", 32'(frame_rises[0]), 32'd11);

    dc = done_cnt[1];
    run_frame(1, 2'd1, 8'h10, 4'h0, 8'h0A, -1, -1, da);
    chk("div1_done_cycle", 32'(da), 32'd51);
    chk("div1_rd_code_rdata", 32'(rdata_v[1]), 32'hA);
    run_frame(1, 2'd3, 8'h11, 4'h0, 8'hC3, -1, -1, da);
    chk("div1_b2b_done_cycle", 32'(da), 32'd51);
    chk("div1_b2b_cs_high_cycles", 32'(last_hirun[1]), 32'd2);
    chk("div1_b2b_rdata", 32'(rdata_v[1]), 32'h1);
    chk("div1_b2b_mosi_stream", 32'(frame_rx[1]), 32'h831100);
    repeat (3) tick();
    chk("div1_b2b_two_dones", 32'(done_cnt[1] - dc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
